// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - VR16 program counter, return-address stack and FETCH/DECODE/EXECUTE sequencer
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mem_ready,
  input  logic                         op_jump,
  input  logic                         op_call,
  input  logic                         op_ret,
  input  logic                         op_halt,
  input  logic                         op_reset_pc,
  input  logic [WIDTH-1:0]             target_addr,
  output logic [WIDTH-1:0]             pc,
  output logic                         fetch_req,
  output logic                         ir_load,
  output logic                         exec_en,
  output logic                         halted,
  output logic                         fault,
  output logic [$clog2(STACK_DEPTH):0] stack_level
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    LVL_FULL = LW'(STACK_DEPTH);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT, S_FAULT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [LW-1:0]    level_next;
  logic             push;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Return addresses wrap modulo 2^WIDTH exactly like sequential pc advance.
  assign pc_inc  = pc + PC_ONE;
  assign top_idx = PW'(stack_level - LVL_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      stack_level <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      stack_level <= level_next;
    end
  end

  // Stack contents are meaningless after reset; only stack_level is cleared.
  always_ff @(posedge clk) begin
    if (push) stack_mem[PW'(stack_level)] <= pc_inc;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    level_next = stack_level;
    push       = 1'b0;
    fetch_req  = 1'b0;
    ir_load    = 1'b0;
    exec_en    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        exec_en    = 1'b1;
        state_next = S_FETCH;
        if (op_halt) begin
          state_next = S_HALT;
        end else if (op_reset_pc) begin
          pc_next = RESET_VECTOR;
        end else if (op_call) begin
          if (stack_level == LVL_FULL) begin
            state_next = S_FAULT;
          end else begin
            push       = 1'b1;
            pc_next    = target_addr;
            level_next = stack_level + LVL_ONE;
          end
        end else if (op_jump) begin
          pc_next = target_addr;
        end else if (op_ret) begin
          if (stack_level == '0) begin
            state_next = S_FAULT;
          end else begin
            pc_next    = stack_mem[top_idx];
            level_next = stack_level - LVL_ONE;
          end
        end else begin
          pc_next = pc_inc;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table, directed and random checks of pc_sequencer against an instruction-level model
module tb_pc_sequencer;
  localparam logic [15:0] RV  = 16'h0000;
  localparam logic [4:0]  NOP = 5'b00000;
  localparam logic [4:0]  RET = 5'b00001;
  localparam logic [4:0]  JMP = 5'b00010;
  localparam logic [4:0]  CAL = 5'b00100;
  localparam logic [4:0]  RPC = 5'b01000;
  localparam logic [4:0]  HLT = 5'b10000;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic        op_jump, op_call, op_ret, op_halt, op_reset_pc;
  logic [15:0] target_addr, pc;
  logic        fetch_req, ir_load, exec_en, halted, fault;
  logic [2:0]  stack_level;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_halt, m_fault;

  typedef struct {
    logic [4:0]  ops;
    logic [15:0] tgt;
    int          stall;
    logic [15:0] exp_pc;
    int          exp_lvl;
    bit          exp_halt;
  } vec_t;
  vec_t tbl[21];

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .op_jump(op_jump), .op_call(op_call), .op_ret(op_ret), .op_halt(op_halt),
    .op_reset_pc(op_reset_pc), .target_addr(target_addr), .pc(pc),
    .fetch_req(fetch_req), .ir_load(ir_load), .exec_en(exec_en),
    .halted(halted), .fault(fault), .stack_level(stack_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_ops(input logic [4:0] o);
    {op_halt, op_reset_pc, op_call, op_jump, op_ret} = o;
  endtask

  task automatic model_exec(input logic [4:0] o, input logic [15:0] tgt);
    if (o[4]) m_halt = 1'b1;
    else if (o[3]) m_pc = RV;
    else if (o[2]) begin
      if (m_stack.size() == 4) m_fault = 1'b1;
      else begin
        m_stack.push_back(m_pc + 16'd1);
        m_pc = tgt;
      end
    end else if (o[1]) m_pc = tgt;
    else if (o[0]) begin
      if (m_stack.size() == 0) m_fault = 1'b1;
      else m_pc = m_stack.pop_back();
    end else m_pc = m_pc + 16'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; set_ops(NOP);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    m_pc = RV; m_stack.delete(); m_halt = 1'b0; m_fault = 1'b0;
    #1;
    chk("reset_pc", 32'(pc), 32'(RV));
    chk("reset_level", 32'(stack_level), 32'd0);
    chk("reset_fetch_req", 32'(fetch_req), 32'd0);
    chk("reset_ir_load", 32'(ir_load), 32'd0);
    chk("reset_exec_en", 32'(exec_en), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b0;
    #1;
    chk("idle_fetch_req", 32'(fetch_req), 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of an instruction's first FETCH cycle; returns at the next one.
  task automatic exec_instr(input logic [4:0] o, input logic [15:0] tgt, input int stall);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = (i == stall);
      set_ops(5'($urandom));
      target_addr = 16'($urandom);
      #1;
      chk("fetch_req", 32'(fetch_req), 32'd1);
      chk("fetch_ir_load", 32'(ir_load), 32'(i == stall));
      chk("fetch_pc", 32'(pc), 32'(m_pc));
      chk("fetch_exec_en", 32'(exec_en), 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'($urandom); set_ops(5'($urandom));
    #1;
    chk("decode_strobes", 32'({fetch_req, ir_load, exec_en}), 32'd0);
    @(negedge clk);
    mem_ready = 1'($urandom); set_ops(o); target_addr = tgt;
    #1;
    chk("exec_en", 32'(exec_en), 32'd1);
    chk("exec_other_strobes", 32'({fetch_req, ir_load}), 32'd0);
    chk("exec_pc", 32'(pc), 32'(m_pc));
    @(negedge clk);
    set_ops(NOP); mem_ready = 1'b0;
    model_exec(o, tgt);
    #1;
    chk("post_pc", 32'(pc), 32'(m_pc));
    chk("post_level", 32'(stack_level), 32'(m_stack.size()));
    chk("post_halted", 32'(halted), 32'(m_halt));
    chk("post_fault", 32'(fault), 32'(m_fault));
    chk("post_fetch_req", 32'(fetch_req), 32'(!(m_halt || m_fault)));
  endtask

  task automatic sticky(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b1; mem_ready = 1'b1; set_ops(5'($urandom)); target_addr = 16'($urandom);
      #1;
      chk("sticky_halted", 32'(halted), 32'(m_halt));
      chk("sticky_fault", 32'(fault), 32'(m_fault));
      chk("sticky_pc", 32'(pc), 32'(m_pc));
      chk("sticky_strobes", 32'({fetch_req, ir_load, exec_en}), 32'd0);
    end
    @(negedge clk);
    start = 1'b0; set_ops(NOP);
  endtask

  initial begin
    logic [4:0]  o;
    logic [15:0] t;
    int          r;

    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; set_ops(NOP); target_addr = '0;
    m_pc = RV; m_halt = 1'b0; m_fault = 1'b0;

    tbl[0]  = '{NOP,       16'h0000, 0, 16'h0001, 0, 1'b0};
    tbl[1]  = '{NOP,       16'h0000, 0, 16'h0002, 0, 1'b0};
    tbl[2]  = '{NOP,       16'h0000, 0, 16'h0003, 0, 1'b0};
    tbl[3]  = '{NOP,       16'h0000, 0, 16'h0004, 0, 1'b0};
    tbl[4]  = '{JMP,       16'h0010, 0, 16'h0010, 0, 1'b0};
    tbl[5]  = '{CAL,       16'h0100, 0, 16'h0100, 1, 1'b0};
    tbl[6]  = '{RET,       16'h0000, 0, 16'h0011, 0, 1'b0};
    tbl[7]  = '{NOP,       16'h0000, 5, 16'h0012, 0, 1'b0};
    tbl[8]  = '{JMP,       16'hFFFF, 0, 16'hFFFF, 0, 1'b0};
    tbl[9]  = '{NOP,       16'h0000, 0, 16'h0000, 0, 1'b0};
    tbl[10] = '{JMP,       16'hFFFF, 0, 16'hFFFF, 0, 1'b0};
    tbl[11] = '{CAL,       16'h0200, 1, 16'h0200, 1, 1'b0};
    tbl[12] = '{RET,       16'h0000, 0, 16'h0000, 0, 1'b0};
    tbl[13] = '{JMP,       16'h0050, 0, 16'h0050, 0, 1'b0};
    tbl[14] = '{CAL,       16'h0060, 0, 16'h0060, 1, 1'b0};
    tbl[15] = '{RPC | CAL, 16'h0300, 2, 16'h0000, 1, 1'b0};
    tbl[16] = '{RET,       16'h0000, 0, 16'h0051, 0, 1'b0};
    tbl[17] = '{CAL | JMP | RET, 16'h0070, 0, 16'h0070, 1, 1'b0};
    tbl[18] = '{JMP | RET, 16'h0080, 0, 16'h0080, 1, 1'b0};
    tbl[19] = '{RET,       16'h0000, 0, 16'h0052, 0, 1'b0};
    tbl[20] = '{HLT | JMP, 16'h1234, 0, 16'h0052, 0, 1'b1};

    do_reset();
    do_start();
    foreach (tbl[i]) begin
      exec_instr(tbl[i].ops, tbl[i].tgt, tbl[i].stall);
      chk("tbl_pc", 32'(pc), 32'(tbl[i].exp_pc));
      chk("tbl_level", 32'(stack_level), 32'(tbl[i].exp_lvl));
      chk("tbl_halted", 32'(halted), 32'(tbl[i].exp_halt));
    end
    sticky(3);

    // Five nested calls into a four-deep stack.
    do_reset();
    do_start();
    exec_instr(CAL, 16'h0100, 0);
    exec_instr(CAL, 16'h0200, 0);
    exec_instr(CAL, 16'h0300, 0);
    exec_instr(CAL, 16'h0400, 0);
    chk("nest4_level", 32'(stack_level), 32'd4);
    exec_instr(CAL, 16'h0500, 0);
    chk("overflow_fault", 32'(fault), 32'd1);
    chk("overflow_pc", 32'(pc), 32'h0400);
    chk("overflow_level", 32'(stack_level), 32'd4);
    sticky(3);

    // LIFO unwind, then underflow.
    do_reset();
    do_start();
    exec_instr(CAL, 16'h0100, 0);
    exec_instr(CAL, 16'h0200, 0);
    exec_instr(CAL, 16'h0300, 0);
    exec_instr(CAL, 16'h0400, 0);
    exec_instr(RET, 16'h0000, 0);
    chk("unwind_pc3", 32'(pc), 32'h0301);
    exec_instr(RET, 16'h0000, 0);
    chk("unwind_pc2", 32'(pc), 32'h0201);
    exec_instr(RET, 16'h0000, 0);
    chk("unwind_pc1", 32'(pc), 32'h0101);
    exec_instr(RET, 16'h0000, 0);
    chk("unwind_pc0", 32'(pc), 32'h0001);
    exec_instr(RET, 16'h0000, 0);
    chk("underflow_fault", 32'(fault), 32'd1);
    chk("underflow_pc", 32'(pc), 32'h0001);

    do_reset();
    do_start();
    exec_instr(RET, 16'h0000, 0);
    chk("empty_ret_fault", 32'(fault), 32'd1);
    chk("empty_ret_pc", 32'(pc), 32'h0000);

    // Reset while FETCH is waiting on memory.
    do_reset();
    do_start();
    exec_instr(JMP, 16'h0040, 0);
    chk("prefetch_pc", 32'(pc), 32'h0040);
    chk("prefetch_req", 32'(fetch_req), 32'd1);
    do_reset();

    do_start();
    for (int n = 0; n < 400; n++) begin
      if (m_halt || m_fault) begin
        sticky(2);
        do_reset();
        do_start();
      end
      r = $urandom_range(0, 19);
      if (r == 0) o = HLT;
      else if (r == 1) o = RPC;
      else if (r <= 5) o = CAL;
      else if (r <= 8) o = JMP;
      else if (r <= 12) o = RET;
      else if (r == 13) o = 5'($urandom);
      else o = NOP;
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      exec_instr(o, t, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
